// File: rtl/line_decoder_seq.sv
// line_decoder_seq
// ----------------
// Sequenced 4-to-16 line decoder. A command (a single line code, or an
// inclusive code range that may wrap past 15) is taken over a valid/ready
// handshake. One registered one-hot line select is then emitted per output
// beat, and the consumer can apply backpressure on each beat.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    command present
//   in_ready    block can accept a command (decoded from state only)
//   in_code     first line to assert
//   in_end      last line to assert (used only when in_sweep=1)
//   in_sweep    1: emit in_code..in_end inclusive, 0: emit in_code only
//   abort       synchronous kill of the current command
//   out_valid   beat present on out_onehot/out_index/out_last
//   out_ready   consumer accepts the current beat
//   out_onehot  one-hot line select (zero when idle)
//   out_index   binary index of the selected line
//   out_last    current beat is the final beat of the command
module line_decoder_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_code,
    input  logic [3:0]  in_end,
    input  logic        in_sweep,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_onehot,
    output logic [3:0]  out_index,
    output logic        out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cur_q, cur_d;
    logic [3:0]  stop_q, stop_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_onehot_q, out_onehot_d;
    logic [3:0]  out_index_q, out_index_d;
    logic        out_last_q, out_last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= 4'd0;
            stop_q       <= 4'd0;
            out_valid_q  <= 1'b0;
            out_onehot_q <= 16'h0000;
            out_index_q  <= 4'd0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            stop_q       <= stop_d;
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
        end
    end

    // Next-state logic. Abort is checked first so that it wins over both
    // command acceptance in IDLE and beat transfer in EMIT.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        stop_d  = stop_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cur_d   = in_code;
                        stop_d  = in_sweep ? in_end : in_code;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (cur_q == stop_q) begin
                            state_d = IDLE;
                        end else begin
                            // 4-bit add: 15 wraps naturally to 0.
                            cur_d = cur_q + 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output registers are loaded from the *next* state so that a beat is
    // visible in the cycle right after acceptance. While a beat is stalled
    // cur/stop/state are unchanged, so these values hold steady.
    always_comb begin
        out_valid_d  = (state_d == EMIT);
        out_onehot_d = 16'h0000;
        out_index_d  = out_index_q;
        out_last_d   = 1'b0;
        if (state_d == EMIT) begin
            out_onehot_d = 16'h0001 << cur_d;
            out_index_d  = cur_d;
            out_last_d   = (cur_d == stop_d);
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_index  = out_index_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_line_decoder_seq.sv
// Directed testbench for line_decoder_seq.
module tb_line_decoder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic [3:0]  in_end;
    logic        in_sweep;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_onehot;
    logic [3:0]  out_index;
    logic        out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    line_decoder_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_end     (in_end),
        .in_sweep   (in_sweep),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_index  (out_index),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // Reference 16-to-4 encoder (the ALU-side counterpart).
    function automatic logic [3:0] enc16(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++)
            if (v[i]) r = r | 4'(i);
        return r;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] code, input logic [3:0] last_code,
                         input logic sweep);
        in_valid = 1'b1;
        in_code  = code;
        in_end   = last_code;
        in_sweep = sweep;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_onehot !== 16'h0000 ||
            out_index !== 4'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b oh=%h idx=%0d last=%b, required 1 0 0000 0 0",
                     in_ready, out_valid, out_onehot, out_index, out_last);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        issue(4'd6, 4'd0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_onehot !== 16'h0040 || out_index !== 4'd6 ||
            out_last !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_beat: vld=%b oh=%h idx=%0d last=%b rdy=%b, required 1 0040 6 1 0",
                     out_valid, out_onehot, out_index, out_last, in_ready);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_onehot !== 16'h0000) begin
            n_fail++;
            $display("FAIL single_done: vld=%b rdy=%b oh=%h, required 0 1 0000",
                     out_valid, in_ready, out_onehot);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_oh [4];
        exp_oh[0] = 16'h4000; exp_oh[1] = 16'h8000;
        exp_oh[2] = 16'h0001; exp_oh[3] = 16'h0002;
        out_ready = 1'b1;
        issue(4'd14, 4'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_onehot !== exp_oh[i] || out_last !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: vld=%b oh=%h last=%b, required 1 %h %b",
                         i, out_valid, out_onehot, out_last, exp_oh[i], (i == 3));
            end
            step();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        // Sweep with in_code == in_end is a single beat.
        issue(4'd5, 4'd5, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_onehot !== 16'h0020 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL equal_sweep: vld=%b oh=%h last=%b, required 1 0020 1",
                     out_valid, out_onehot, out_last);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL equal_sweep_done: vld=%b, required 0", out_valid);
        end
    endtask

    task automatic test_full_backpressure();
        int xfers;
        int exp_idx;
        logic rdy;
        xfers   = 0;
        exp_idx = 0;
        rdy     = 1'b1;
        out_ready = 1'b1;
        issue(4'd0, 4'd15, 1'b1);
        for (int cyc = 0; cyc < 60 && out_valid === 1'b1; cyc++) begin
            out_ready = rdy;
            n_cmp++;
            if (out_onehot !== (16'h0001 << exp_idx) || out_index !== 4'(exp_idx) ||
                out_last !== (exp_idx == 15)) begin
                n_fail++;
                $display("FAIL full_bp_cyc%0d: oh=%h idx=%0d last=%b, required %h %0d %b",
                         cyc, out_onehot, out_index, out_last, 16'h0001 << exp_idx,
                         exp_idx, (exp_idx == 15));
            end
            if (rdy) begin
                xfers++;
                exp_idx++;
            end
            rdy = ~rdy;
            step();
        end
        out_ready = 1'b1;
        n_cmp++;
        if (xfers !== 16 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_bp_count: xfers=%0d vld=%b rdy=%b, required 16 0 1",
                     xfers, out_valid, in_ready);
        end
    endtask

    task automatic test_round_trip();
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            issue(4'(c), 4'd0, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b1 || enc16(out_onehot) !== 4'(c) || out_index !== 4'(c) ||
                out_onehot !== (16'h0001 << c)) begin
                n_fail++;
                $display("FAIL round_trip_%0d: vld=%b oh=%h enc=%0d idx=%0d, required 1 %h %0d %0d",
                         c, out_valid, out_onehot, enc16(out_onehot), out_index,
                         16'h0001 << c, c, c);
            end
            step();
        end
    endtask

    task automatic test_abort();
        int guard;
        out_ready = 1'b1;
        issue(4'd3, 4'd10, 1'b1);
        guard = 0;
        while (out_index !== 4'd5 && guard < 20) begin
            step();
            guard++;
        end
        n_cmp++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL abort_reach5: idx=%0d, required 5 within 20 cycles", out_index);
        end
        step();  // beat 5 transferred; beat 6 now presented
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_onehot !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_idle: vld=%b rdy=%b oh=%h, required 0 1 0000",
                     out_valid, in_ready, out_onehot);
        end
        issue(4'd9, 4'd0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_onehot !== 16'h0200 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_next: vld=%b oh=%h last=%b, required 1 0200 1",
                     out_valid, out_onehot, out_last);
        end
        step();
        // Abort wins over a command offered in IDLE.
        abort = 1'b1;
        issue(4'd2, 4'd0, 1'b0);
        abort = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_priority: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        int guard;
        out_ready = 1'b1;
        issue(4'd0, 4'd15, 1'b1);
        guard = 0;
        while (out_index !== 4'd7 && guard < 20) begin
            step();
            guard++;
        end
        n_cmp++;
        if (guard >= 20 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_reach7: idx=%0d vld=%b, required 7 1", out_index, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_onehot !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_index !== 4'd0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: oh=%h vld=%b rdy=%b idx=%0d last=%b, required 0000 0 1 0 0",
                     out_onehot, out_valid, in_ready, out_index, out_last);
        end
        step();
        rst = 1'b0;
        step();
        issue(4'd12, 4'd0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_onehot !== 16'h1000 || out_index !== 4'd12) begin
            n_fail++;
            $display("FAIL areset_recover: vld=%b oh=%h idx=%0d, required 1 1000 12",
                     out_valid, out_onehot, out_index);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_code = 4'd0;
        in_end = 4'd0;
        in_sweep = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_single();
        test_wrap();
        test_full_backpressure();
        test_round_trip();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
